// File: rtl/shift_ex_stage.sv
// -----------------------------------------------------------------------------
// shift_ex_stage -- two-register shift execute stage (S1 operand latch, S2
// result latch) with a valid/ready handshake on both sides.
//
// An R-type bundle is decoded when S1 loads:
//   op  = funct[1:0]
//   amt = funct[2] ? rs[4:0] : shamt
//   a   = rt
// Supported funct values: sll, srl, sra, sllv, srlv, srav. Any other funct
// produces a zero result with out_err set. The shifter sits combinationally
// between S1 and S2, so a bundle accepted at edge N is presented on the
// output after edge N+1.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   flush           synchronous kill of both stages (rst has priority)
//   in_valid/ready  upstream handshake
//   in_funct        funct field (6)
//   in_rs, in_rt    register operands (32)
//   in_shamt, in_rd shamt field, destination tag (5)
//   out_valid/ready downstream handshake
//   out_result      shift result (32)
//   out_rd          destination tag of out_result (5)
//   out_err         unsupported-funct flag for the presented bundle
//   op_count        completed-op counter (32)
//
// Configuration macro: SHIFT_EX_STAGE_CNT_EN
//   defined   -> op_count counts output handshakes, wraps, cleared only by rst
//   undefined -> op_count is tied to zero and no counter is built
// -----------------------------------------------------------------------------

// Combinational 32-bit shifter; op follows the low two funct bits.
module shifter (
    input  logic [31:0] a,
    input  logic [4:0]  amt,
    input  logic [1:0]  op,
    output logic [31:0] y
);
    always_comb begin
        // NOTE: give every combinational output a default first so that no
        // path through the case leaves it unassigned (which infers a latch).
        y = a;
        case (op)
            2'b00:   y = a << amt;
            2'b10:   y = a >> amt;
            2'b11:   y = 32'($signed(a) >>> amt);
            default: y = a;   // op 01 only arises from unsupported funct values
        endcase
    end
endmodule

module shift_ex_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [5:0]  in_funct,
    input  logic [31:0] in_rs,
    input  logic [31:0] in_rt,
    input  logic [4:0]  in_shamt,
    input  logic [4:0]  in_rd,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [4:0]  out_rd,
    output logic        out_err,
    output logic [31:0] op_count
);
    // S1 operand latch
    logic        s1_valid;
    logic [31:0] s1_a;
    logic [4:0]  s1_amt;
    logic [1:0]  s1_op;
    logic        s1_err;
    logic [4:0]  s1_rd;

    // S2 valid; the S2 payload registers are the output ports themselves
    logic        s2_valid;

    logic        accept;
    logic        s1_adv;
    logic        s2_drain;
    logic        funct_ok;
    logic [31:0] shift_y;

    // Only rs[4:0] ever contributes to the shift amount.
    logic        unused_rs_bits;
    assign unused_rs_bits = ^in_rs[31:5];

    // Handshake control. in_ready looks through to out_ready so a full
    // pipeline still accepts one bundle per cycle while downstream drains.
    assign s2_drain  = s2_valid && out_ready;
    assign s1_adv    = s1_valid && (!s2_valid || out_ready);
    assign in_ready  = !s1_valid || s1_adv;
    assign accept    = in_valid && in_ready;
    assign out_valid = s2_valid;

    always_comb begin
        funct_ok = 1'b0;
        case (in_funct)
            6'b000000, 6'b000010, 6'b000011,
            6'b000100, 6'b000110, 6'b000111: funct_ok = 1'b1;
            default:                         funct_ok = 1'b0;
        endcase
    end

    shifter u_shifter (
        .a   (s1_a),
        .amt (s1_amt),
        .op  (s1_op),
        .y   (shift_y)
    );

    // Valid bits and output registers: rst beats flush beats handshakes.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is written with non-blocking assignments so
        // every flop samples pre-edge values regardless of statement order.
        if (rst) begin
            s1_valid   <= 1'b0;
            s2_valid   <= 1'b0;
            out_result <= '0;
            out_rd     <= '0;
            out_err    <= 1'b0;
        end else if (flush) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (accept)
                s1_valid <= 1'b1;
            else if (s1_adv)
                s1_valid <= 1'b0;

            if (s1_adv) begin
                s2_valid   <= 1'b1;
                out_result <= s1_err ? 32'h0000_0000 : shift_y;
                out_rd     <= s1_rd;
                out_err    <= s1_err;
            end else if (s2_drain) begin
                s2_valid <= 1'b0;
            end
        end
    end

    // S1 payload is qualified by s1_valid, so it needs no reset.
    // NOTE: datapath registers guarded by a valid bit are left unreset; only
    // control state and architecturally visible outputs are reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            s1_a   <= in_rt;
            s1_amt <= in_funct[2] ? in_rs[4:0] : in_shamt;
            s1_op  <= in_funct[1:0];
            s1_err <= !funct_ok;
            s1_rd  <= in_rd;
        end
    end

`ifdef SHIFT_EX_STAGE_CNT_EN
    // Counts every output handshake; flush does not clear it.
    logic [31:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else if (s2_drain)
            cnt_q <= cnt_q + 32'd1;
    end

    assign op_count = cnt_q;
`else
    assign op_count = '0;
`endif

endmodule

// File: tb/tb_shift_ex_stage.sv
// -----------------------------------------------------------------------------
// tb_shift_ex_stage -- scoreboard bench for shift_ex_stage.
// The driver issues bundles and pushes the reference result for each accepted
// bundle; an independent monitor pops and compares on every output handshake,
// and also tracks in_ready, output stability under backpressure and op_count.
// Honours SHIFT_EX_STAGE_CNT_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_shift_ex_stage;

    typedef struct {
        logic [5:0]  funct;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [4:0]  shamt;
        logic [4:0]  rd;
    } bundle_t;

    typedef struct {
        logic [31:0] result;
        logic [4:0]  rd;
        logic        err;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  in_funct;
    logic [31:0] in_rs;
    logic [31:0] in_rt;
    logic [4:0]  in_shamt;
    logic [4:0]  in_rd;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
    logic        out_err;
    logic [31:0] op_count;

    int   tests  = 0;
    int   fails  = 0;
    exp_t exp_q[$];
    logic mon_on = 1'b0;
    logic [31:0] cnt_model = '0;

    shift_ex_stage dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_funct   (in_funct),
        .in_rs      (in_rs),
        .in_rt      (in_rt),
        .in_shamt   (in_shamt),
        .in_rd      (in_rd),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_rd     (out_rd),
        .out_err    (out_err),
        .op_count   (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: MIPS shift semantics straight from the instruction definitions.
    function automatic exp_t model(input bundle_t b);
        exp_t e;
        int   amt;
        amt      = b.funct[2] ? int'(b.rs % 32) : int'(b.shamt);
        e.rd     = b.rd;
        e.err    = 1'b0;
        e.result = '0;
        case (b.funct)
            6'd0, 6'd4: e.result = b.rt << amt;                        // sll, sllv
            6'd2, 6'd6: e.result = b.rt >> amt;                        // srl, srlv
            6'd3, 6'd7: e.result = 32'($signed(b.rt) >>> amt);         // sra, srav
            default:    e.err    = 1'b1;
        endcase
        return e;
    endfunction

    // One clock cycle of stimulus; returns whether the bundle was accepted.
    task automatic drive(input logic v, input bundle_t b, input logic ordy,
                         input logic fl, input logic r, output logic acc);
        in_valid  = v;
        in_funct  = b.funct;
        in_rs     = b.rs;
        in_rt     = b.rt;
        in_shamt  = b.shamt;
        in_rd     = b.rd;
        out_ready = ordy;
        flush     = fl;
        rst       = r;
        @(negedge clk);
        #2;
        acc = v && in_ready && !fl && !r;
        if (acc) exp_q.push_back(model(b));
        @(posedge clk);
        #1;
    endtask

    function automatic bundle_t rand_bundle();
        bundle_t b;
        case ($urandom_range(0, 7))
            0: b.funct = 6'd0;
            1: b.funct = 6'd2;
            2: b.funct = 6'd3;
            3: b.funct = 6'd4;
            4: b.funct = 6'd6;
            5: b.funct = 6'd7;
            default: b.funct = 6'($urandom);
        endcase
        b.rs    = $urandom;
        b.rt    = $urandom;
        b.shamt = 5'($urandom);
        b.rd    = 5'($urandom);
        return b;
    endfunction

    // Output monitor / scoreboard.
    initial begin : monitor
        logic  hold_pending;
        exp_t  held;
        exp_t  e;
        hold_pending = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_on) begin
                if (!rst)
                    check("in_ready", in_ready, (exp_q.size() < 2 || out_ready) ? 1 : 0);
                check("op_count", op_count, cnt_model);
                if (exp_q.size() == 0)
                    check("idle_out_valid", out_valid, 0);
                if (hold_pending) begin
                    check("stall_valid", out_valid, 1);
                    check("stall_result", out_result, held.result);
                    check("stall_rd", out_rd, held.rd);
                    check("stall_err", out_err, held.err);
                end
                hold_pending = out_valid && !out_ready && !flush && !rst;
                held.result  = out_result;
                held.rd      = out_rd;
                held.err     = out_err;
                if (out_valid && out_ready && !rst) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_output", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("result", out_result, e.result);
                        check("rd", out_rd, e.rd);
                        check("err", out_err, e.err);
`ifdef SHIFT_EX_STAGE_CNT_EN
                        cnt_model = cnt_model + 32'd1;
`endif
                    end
                end
                if (flush || rst) begin
                    exp_q.delete();
                    hold_pending = 1'b0;
                end
                if (rst) cnt_model = '0;
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        bundle_t idle;
        bundle_t b;
        bundle_t b1;
        bundle_t b2;
        bundle_t b3;
        logic    acc;
        logic    ordy;
        logic    fl;
        logic    r;
        idle = '{funct: 6'd0, rs: '0, rt: '0, shamt: '0, rd: '0};

        // Reset
        drive(1'b0, idle, 1'b0, 1'b0, 1'b1, acc);
        mon_on = 1'b1;
        drive(1'b0, idle, 1'b0, 1'b0, 1'b1, acc);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_result", out_result, 0);
        check("rst_out_rd", out_rd, 0);
        check("rst_out_err", out_err, 0);
        check("rst_op_count", op_count, 0);
        check("rst_in_ready", in_ready, 1);

        // sll with latency check
        b = '{funct: 6'b000000, rs: 32'h0, rt: 32'h0000_000F, shamt: 5'd4, rd: 5'd3};
        drive(1'b1, b, 1'b1, 1'b0, 1'b0, acc);
        check("sll_accept", acc, 1);
        check("sll_not_yet", out_valid, 0);
        drive(1'b0, idle, 1'b1, 1'b0, 1'b0, acc);
        check("sll_valid", out_valid, 1);
        check("sll_result", out_result, 32'h0000_00F0);
        check("sll_err", out_err, 0);

        // srav then srlv back to back
        b1 = '{funct: 6'b000111, rs: 32'h0000_0024, rt: 32'h8000_0000, shamt: 5'd0, rd: 5'd4};
        b2 = '{funct: 6'b000110, rs: 32'h0000_0024, rt: 32'h8000_0000, shamt: 5'd0, rd: 5'd5};
        drive(1'b1, b1, 1'b1, 1'b0, 1'b0, acc);
        drive(1'b1, b2, 1'b1, 1'b0, 1'b0, acc);
        check("srav_result", out_result, 32'hF800_0000);
        drive(1'b0, idle, 1'b1, 1'b0, 1'b0, acc);
        check("srlv_result", out_result, 32'h0800_0000);
        check("srlv_rd", out_rd, 5'd5);

        // Unsupported funct
        b = '{funct: 6'b100000, rs: 32'h0, rt: 32'h1234_5678, shamt: 5'd3, rd: 5'd9};
        drive(1'b1, b, 1'b1, 1'b0, 1'b0, acc);
        drive(1'b0, idle, 1'b1, 1'b0, 1'b0, acc);
        check("unsup_result", out_result, 32'h0);
        check("unsup_err", out_err, 1);
        check("unsup_rd", out_rd, 5'd9);
        drive(1'b0, idle, 1'b1, 1'b0, 1'b0, acc);

        // Backpressure: out_ready low for four cycles
        b1 = '{funct: 6'b000000, rs: 32'h0, rt: 32'h0000_0001, shamt: 5'd1,  rd: 5'd1};
        b2 = '{funct: 6'b000011, rs: 32'h0, rt: 32'hF000_0000, shamt: 5'd8,  rd: 5'd2};
        b3 = '{funct: 6'b000100, rs: 32'h1F, rt: 32'h0000_0003, shamt: 5'd0, rd: 5'd3};
        drive(1'b1, b1, 1'b0, 1'b0, 1'b0, acc);
        check("bp_acc1", acc, 1);
        drive(1'b1, b2, 1'b0, 1'b0, 1'b0, acc);
        check("bp_acc2", acc, 1);
        drive(1'b1, b3, 1'b0, 1'b0, 1'b0, acc);
        check("bp_full_reject", acc, 0);
        drive(1'b1, b3, 1'b0, 1'b0, 1'b0, acc);
        check("bp_full_reject2", acc, 0);
        check("bp_hold_rd", out_rd, 5'd1);
        drive(1'b1, b3, 1'b1, 1'b0, 1'b0, acc);
        check("bp_acc3", acc, 1);
        for (int i = 0; i < 4; i++) drive(1'b0, idle, 1'b1, 1'b0, 1'b0, acc);
        check("bp_drained", exp_q.size(), 0);

        // Flush with both stages full
        drive(1'b1, b1, 1'b0, 1'b0, 1'b0, acc);
        drive(1'b1, b2, 1'b0, 1'b0, 1'b0, acc);
        drive(1'b1, b3, 1'b0, 1'b1, 1'b0, acc);
        check("flush_out_valid", out_valid, 0);
        check("flush_in_ready", in_ready, 1);
        drive(1'b0, idle, 1'b1, 1'b0, 1'b0, acc);

        // Counter: reset, five completed ops, reset again
        drive(1'b0, idle, 1'b0, 1'b0, 1'b1, acc);
        check("cnt_after_rst", op_count, 0);
        for (int i = 0; i < 5; i++) drive(1'b1, rand_bundle(), 1'b1, 1'b0, 1'b0, acc);
        for (int i = 0; i < 3; i++) drive(1'b0, idle, 1'b1, 1'b0, 1'b0, acc);
`ifdef SHIFT_EX_STAGE_CNT_EN
        check("cnt_five", op_count, 5);
`else
        check("cnt_five", op_count, 0);
`endif
        drive(1'b0, idle, 1'b0, 1'b0, 1'b1, acc);
        check("cnt_cleared", op_count, 0);

        // Randomised traffic with occasional flush and reset
        for (int i = 0; i < 600; i++) begin
            fl   = ($urandom_range(0, 99) < 3);
            r    = ($urandom_range(0, 199) == 0);
            ordy = ($urandom_range(0, 3) != 0) && !fl && !r;
            drive($urandom_range(0, 9) < 7, rand_bundle(), ordy, fl, r, acc);
        end
        for (int i = 0; i < 4; i++) drive(1'b0, idle, 1'b1, 1'b0, 1'b0, acc);
        check("final_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
